// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control: opcodes, select codes,
// the FSM state enum and the packed control-output vector.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXE    = 4'd7,
    S_R_WB     = 4'd8,
    S_BEQ      = 4'd9,
    S_JMP      = 4'd10,
    S_ADDI_EXE = 4'd11,
    S_ADDI_WB  = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Combinational mapping from (state, mem_ready) to the datapath control vector.
// Everything not explicitly driven for a state stays 0.
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC only load in the cycle the read actually completes
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_R_EXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDI_WB: ctrl.reg_write  = 1'b1;
      S_TRAP:    ctrl.illegal_op = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: state register, next-state logic and
// retired-instruction counter; output decode lives in mc_output_decode.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_t state, state_nxt;
  ctrl_t  ctrl;
  logic   retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_RTYPE:     state_nxt = S_R_EXE;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_J:         state_nxt = S_JMP;
          OP_ADDI:      state_nxt = S_ADDI_EXE;
          default:      state_nxt = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_nxt = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_nxt = S_FETCH;
      S_R_EXE:    state_nxt = S_R_WB;
      S_ADDI_EXE: state_nxt = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BEQ, S_JMP, S_ADDI_WB: state_nxt = S_FETCH;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_TRAP;
    endcase
  end

  // An instruction retires on the edge that leaves its final state
  always_comb begin
    retire = 1'b0;
    case (state)
      S_MEM_WB, S_R_WB, S_BEQ, S_JMP, S_ADDI_WB: retire = 1'b1;
      S_MEM_WR: retire = mem_ready;
      default:  retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instr_count <= '0;
    else if (retire) instr_count <= instr_count + CNT_W'(1);
  end

  mc_output_decode u_decode (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign illegal_op  = ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control; a CNT_W=4 copy shares the
// stimulus so counter wrap is observed alongside the full-width counter.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;

  logic        pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill;
  logic [1:0]  srcb, aluop, pcsrc;
  logic [31:0] cnt;

  logic        pcw4, pcwc4, iord4, mrd4, mwr4, irw4, m2r4, rdst4, rw4, srca4, ill4;
  logic [1:0]  srcb4, aluop4, pcsrc4;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .MemRead(mrd), .MemWrite(mwr),
    .IRWrite(irw), .MemtoReg(m2r), .RegDst(rdst), .RegWrite(rw), .ALUSrcA(srca),
    .ALUSrcB(srcb), .ALUOp(aluop), .PCSource(pcsrc), .illegal_op(ill),
    .instr_count(cnt)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(pcw4), .PCWriteCond(pcwc4), .IorD(iord4), .MemRead(mrd4), .MemWrite(mwr4),
    .IRWrite(irw4), .MemtoReg(m2r4), .RegDst(rdst4), .RegWrite(rw4), .ALUSrcA(srca4),
    .ALUSrcB(srcb4), .ALUOp(aluop4), .PCSource(pcsrc4), .illegal_op(ill4),
    .instr_count(cnt4)
  );

  // Expected vector layout: pcw pcwc iord mrd mwr irw m2r rdst rw srca srcb aluop pcsrc ill
  localparam logic [16:0] E_IDLE   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_FWAIT  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] E_FGO    = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] E_DEC    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] E_MADDR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] E_MRD    = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_MWB    = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] E_MWR    = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_REXE   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] E_RWB    = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] E_BEQ    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] E_JMP    = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] E_AEXE   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] E_AWB    = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [16:0] E_TRAP   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, AD = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct {
    logic [16:0] ctrl;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  exp_t sb[$];

  task automatic check_out();
    exp_t        e;
    logic [16:0] obs, obs4;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty obs=0 exp=1");
      return;
    end
    e    = sb.pop_front();
    obs  = {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc, ill};
    obs4 = {pcw4, pcwc4, iord4, mrd4, mwr4, irw4, m2r4, rdst4, rw4, srca4, srcb4, aluop4, pcsrc4, ill4};
    checks++;
    assert (obs === e.ctrl) else begin
      errors++;
      $error("FAIL %s_ctrl obs=%b exp=%b", e.tag, obs, e.ctrl);
    end
    checks++;
    assert (cnt === e.cnt) else begin
      errors++;
      $error("FAIL %s_count obs=%0d exp=%0d", e.tag, cnt, e.cnt);
    end
    checks++;
    assert (obs4 === e.ctrl) else begin
      errors++;
      $error("FAIL %s_ctrl4 obs=%b exp=%b", e.tag, obs4, e.ctrl);
    end
    checks++;
    assert (cnt4 === e.cnt[3:0]) else begin
      errors++;
      $error("FAIL %s_count4 obs=%0d exp=%0d", e.tag, cnt4, e.cnt[3:0]);
    end
  endtask

  // One cycle: drive on the falling edge, check outputs 1ns later, before the next rise
  task automatic step(input logic rst, input logic [5:0] op, input logic rdy,
                      input logic [16:0] ex, input logic [31:0] c, input string tag);
    exp_t e;
    @(negedge clk);
    rst_n     = rst;
    opcode    = op;
    mem_ready = rdy;
    e.ctrl = ex;
    e.cnt  = c;
    e.tag  = tag;
    sb.push_back(e);
    #1;
    check_out();
  endtask

  initial begin
    logic [31:0] c;
    rst_n     = 1'b0;
    opcode    = LW;
    mem_ready = 1'b1;
    c         = 0;

    for (int i = 0; i < 3; i++) step(1'b0, LW, 1'b1, E_IDLE, 0, "reset");
    step(1'b1, LW, 1'b1, E_IDLE, 0, "idle_after_release");

    // lw, no stalls
    step(1'b1, LW, 1'b1, E_FGO,   c, "lw_fetch");
    step(1'b1, LW, 1'b1, E_DEC,   c, "lw_decode");
    step(1'b1, LW, 1'b1, E_MADDR, c, "lw_memaddr");
    step(1'b1, LW, 1'b1, E_MRD,   c, "lw_memrd");
    step(1'b1, LW, 1'b1, E_MWB,   c, "lw_memwb");
    c = c + 1;

    // addi behind a 4-cycle fetch stall
    for (int i = 0; i < 4; i++) step(1'b1, AD, 1'b0, E_FWAIT, c, "fetch_stall");
    step(1'b1, AD, 1'b1, E_FGO,  c, "addi_fetch");
    step(1'b1, AD, 1'b0, E_DEC,  c, "addi_decode_rdy_ignored");
    step(1'b1, AD, 1'b0, E_AEXE, c, "addi_exe");
    step(1'b1, AD, 1'b1, E_AWB,  c, "addi_wb");
    c = c + 1;

    // R-type; opcode changes after decode must not matter
    step(1'b1, RT,  1'b1, E_FGO,  c, "r_fetch");
    step(1'b1, RT,  1'b1, E_DEC,  c, "r_decode");
    step(1'b1, BAD, 1'b1, E_REXE, c, "r_exe");
    step(1'b1, BAD, 1'b1, E_RWB,  c, "r_wb");
    c = c + 1;
    step(1'b1, BQ, 1'b1, E_FGO, c, "beq_fetch");
    step(1'b1, BQ, 1'b1, E_DEC, c, "beq_decode");
    step(1'b1, BQ, 1'b1, E_BEQ, c, "beq");
    c = c + 1;
    step(1'b1, JJ, 1'b1, E_FGO, c, "j_fetch");
    step(1'b1, JJ, 1'b1, E_DEC, c, "j_decode");
    step(1'b1, JJ, 1'b1, E_JMP, c, "jmp");
    c = c + 1;

    // sw with two wait cycles in MEM_WR
    step(1'b1, SW, 1'b1, E_FGO,   c, "sw_fetch");
    step(1'b1, SW, 1'b1, E_DEC,   c, "sw_decode");
    step(1'b1, SW, 1'b1, E_MADDR, c, "sw_memaddr");
    step(1'b1, SW, 1'b0, E_MWR,   c, "sw_wait1");
    step(1'b1, SW, 1'b0, E_MWR,   c, "sw_wait2");
    step(1'b1, SW, 1'b1, E_MWR,   c, "sw_done");
    c = c + 1;

    // lw with one wait in MEM_RD
    step(1'b1, LW, 1'b1, E_FGO,   c, "lw2_fetch");
    step(1'b1, LW, 1'b1, E_DEC,   c, "lw2_decode");
    step(1'b1, LW, 1'b1, E_MADDR, c, "lw2_memaddr");
    step(1'b1, LW, 1'b0, E_MRD,   c, "lw2_memrd_wait");
    step(1'b1, LW, 1'b1, E_MRD,   c, "lw2_memrd");
    step(1'b1, LW, 1'b1, E_MWB,   c, "lw2_memwb");
    c = c + 1;

    // Jumps until 16 retires: the 4-bit counter wraps to 0
    while (c < 16) begin
      step(1'b1, JJ, 1'b1, E_FGO, c, "wrap_fetch");
      step(1'b1, JJ, 1'b1, E_DEC, c, "wrap_decode");
      step(1'b1, JJ, 1'b1, E_JMP, c, "wrap_jmp");
      c = c + 1;
    end
    step(1'b1, LW, 1'b1, E_FGO, c, "wrapped_count");

    // Reset asserted while waiting in MEM_RD
    step(1'b1, LW, 1'b1, E_DEC,   c, "rst_lw_decode");
    step(1'b1, LW, 1'b1, E_MADDR, c, "rst_lw_memaddr");
    step(1'b1, LW, 1'b0, E_MRD,   c, "rst_lw_memrd");
    c = 0;
    step(1'b0, LW, 1'b1, E_IDLE, c, "async_reset_memrd");
    step(1'b0, LW, 1'b1, E_IDLE, c, "reset_hold");
    step(1'b1, LW, 1'b1, E_IDLE, c, "idle_again");

    // Illegal opcode: absorbing trap, no retire
    step(1'b1, BAD, 1'b1, E_FGO, c, "bad_fetch");
    step(1'b1, BAD, 1'b1, E_DEC, c, "bad_decode");
    for (int i = 0; i < 5; i++)
      step(1'b1, (i % 2 == 0) ? LW : RT, i[0], E_TRAP, c, "trap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
